// File: rtl/uart_vga_system.sv
// Glove-display top: UART RX colour code, 640x480@60 VGA field with white border.
// Optional UART echo of each good byte is built when UART_ECHO_EN is defined.
module uart_vga_system #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int BORDER_PX    = 8,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       uart_0_external_connection_rxd,
  output logic       uart_0_external_connection_txd,
  output logic [7:0] o_VGA_R,
  output logic [7:0] o_VGA_G,
  output logic [7:0] o_VGA_B,
  output logic       o_VGA_HS,
  output logic       o_VGA_VS,
  output logic       o_VGA_blank,
  output logic       o_VGA_sync,
  output logic       o_VGA_clk
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int CW       = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // 3-3-2 colour code widened to 8 bits per channel by bit replication
  function automatic logic [23:0] expand_rgb(input logic [7:0] c);
    return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], {4{c[1:0]}}};
  endfunction

  logic          pix_en;
  logic [HW-1:0] h_p0;
  logic [VW-1:0] v_p0;
  logic          frame_start;
  logic          visible, border, hs_c, vs_c;
  logic          hs_p1, vs_p1, blank_p1;
  logic [23:0]   rgb_p1;
  logic [7:0]    colour, pending;

  logic          rx_meta, rx_sync;
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_idx, rx_idx_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          rx_valid, rx_valid_n;

  // ---- stage p0: pixel clock enable and raster counters
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      pix_en <= 1'b0;
      h_p0   <= '0;
      v_p0   <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_p0 == HW'(H_TOTAL - 1)) begin
          h_p0 <= '0;
          v_p0 <= (v_p0 == VW'(V_TOTAL - 1)) ? '0 : v_p0 + 1'b1;
        end else begin
          h_p0 <= h_p0 + 1'b1;
        end
      end
    end
  end

  always_comb begin
    visible = (h_p0 < HW'(H_ACTIVE)) && (v_p0 < VW'(V_ACTIVE));
    border  = (h_p0 < HW'(BORDER_PX)) || (h_p0 >= HW'(H_ACTIVE - BORDER_PX)) ||
              (v_p0 < VW'(BORDER_PX)) || (v_p0 >= VW'(V_ACTIVE - BORDER_PX));
    hs_c    = !((h_p0 >= HW'(H_ACTIVE + H_FP)) && (h_p0 < HW'(H_ACTIVE + H_FP + H_SYNC)));
    vs_c    = !((v_p0 >= VW'(V_ACTIVE + V_FP)) && (v_p0 < VW'(V_ACTIVE + V_FP + V_SYNC)));
  end

  assign frame_start = pix_en && (h_p0 == '0) && (v_p0 == '0);

  // ---- stage p1: registered sync, blank and pixel colour
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      hs_p1    <= 1'b1;
      vs_p1    <= 1'b1;
      blank_p1 <= 1'b0;
      rgb_p1   <= '0;
    end else begin
      hs_p1    <= hs_c;
      vs_p1    <= vs_c;
      blank_p1 <= visible;
      if (!visible)    rgb_p1 <= '0;
      else if (border) rgb_p1 <= '1;
      else             rgb_p1 <= expand_rgb(colour);
    end
  end

  assign o_VGA_R     = rgb_p1[23:16];
  assign o_VGA_G     = rgb_p1[15:8];
  assign o_VGA_B     = rgb_p1[7:0];
  assign o_VGA_HS    = hs_p1;
  assign o_VGA_VS    = vs_p1;
  assign o_VGA_blank = blank_p1;
  assign o_VGA_sync  = 1'b0;
  assign o_VGA_clk   = pix_en;

  // Colour only changes at frame start so a frame is never drawn in two colours
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      pending <= 8'h00;
      colour  <= 8'h00;
    end else begin
      if (rx_valid)    pending <= rx_shift;
      if (frame_start) colour  <= rx_valid ? rx_shift : pending;
    end
  end

  // ---- UART receive: synchroniser and framing FSM
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_0_external_connection_rxd;
      rx_sync <= rx_meta;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_valid_n = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        rx_idx_n = '0;
        if (!rx_sync) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == CW'(HALF_BIT - 1)) begin
          rx_cnt_n   = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          rx_idx_n   = rx_idx + 1'b1;
          if (rx_idx == 3'd7) rx_state_n = RX_STOP;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
          rx_cnt_n   = '0;
          rx_valid_n = rx_sync;
          rx_state_n = RX_IDLE;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_valid <= rx_valid_n;
    end
  end

  always_ff @(posedge clk_clk) begin
    rx_shift <= rx_shift_n;
  end

`ifdef UART_ECHO_EN
  logic          tx_busy;
  logic          tx_line;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bits;
  logic [8:0]    tx_data;
  logic          tx_bit_end;

  assign tx_bit_end = (tx_cnt == CW'(CLKS_PER_BIT - 1));

  // ---- UART echo: start bit on load, then 8 data bits and stop from tx_data
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      tx_busy <= 1'b0;
      tx_line <= 1'b1;
      tx_cnt  <= '0;
      tx_bits <= '0;
    end else if (!tx_busy) begin
      if (rx_valid) begin
        tx_busy <= 1'b1;
        tx_line <= 1'b0;
        tx_cnt  <= '0;
        tx_bits <= '0;
      end
    end else if (tx_bit_end) begin
      tx_cnt <= '0;
      if (tx_bits == 4'd9) begin
        tx_busy <= 1'b0;
        tx_line <= 1'b1;
      end else begin
        tx_line <= tx_data[0];
        tx_bits <= tx_bits + 1'b1;
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!tx_busy && rx_valid)                     tx_data <= {1'b1, rx_shift};
    else if (tx_busy && tx_bit_end && tx_bits != 4'd9) tx_data <= {1'b1, tx_data[8:1]};
  end

  assign uart_0_external_connection_txd = tx_line;
`else
  assign uart_0_external_connection_txd = 1'b1;
`endif

endmodule

// File: tb/tb_uart_vga_system.sv
// Randomised bench for uart_vga_system on a shrunken raster and fast UART,
// compared cycle by cycle against a frame/pixel arithmetic model.
module tb_uart_vga_system;

  localparam int CPB   = 50;
  localparam int H_ACT = 32, H_FPW = 2, H_SYW = 4, H_BPW = 2;
  localparam int V_ACT = 24, V_FPW = 1, V_SYW = 2, V_BPW = 2;
  localparam int HT    = H_ACT + H_FPW + H_SYW + H_BPW;
  localparam int VT    = V_ACT + V_FPW + V_SYW + V_BPW;
  localparam int FR    = HT * VT;
  localparam int BPX   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       txd;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank, vga_sync, vga_clk;

  always #10 clk = ~clk;

  uart_vga_system #(
    .CLK_HZ(50_000_000), .BAUD(1_000_000), .BORDER_PX(BPX),
    .H_ACTIVE(H_ACT), .H_FP(H_FPW), .H_SYNC(H_SYW), .H_BP(H_BPW),
    .V_ACTIVE(V_ACT), .V_FP(V_FPW), .V_SYNC(V_SYW), .V_BP(V_BPW)
  ) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .uart_0_external_connection_rxd(rxd),
    .uart_0_external_connection_txd(txd),
    .o_VGA_R(vga_r),
    .o_VGA_G(vga_g),
    .o_VGA_B(vga_b),
    .o_VGA_HS(vga_hs),
    .o_VGA_VS(vga_vs),
    .o_VGA_blank(vga_blank),
    .o_VGA_sync(vga_sync),
    .o_VGA_clk(vga_clk)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // n = clock edges since reset was released (0 while in reset)
  int         n = 0;
  bit         mon_en = 1'b0;
  logic [7:0] m_colour = 8'h00;
  logic [7:0] m_pending = 8'h00;
  event       fs_ev;

  always @(posedge clk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  // Expected {hs, vs, blank, vga_clk, sync, txd, R, G, B} after edge nn
  function automatic logic [29:0] ref_vga(input int nn, input logic [7:0] c);
    int p, h, v, r3, g3, b2;
    logic vis, bord, hs, vs;
    logic [7:0] r, g, b;
    if (nn == 0) return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0};
    p    = (nn - 1) / 2;
    h    = p % HT;
    v    = (p / HT) % VT;
    vis  = (h < H_ACT) && (v < V_ACT);
    bord = (h < BPX) || (h >= H_ACT - BPX) || (v < BPX) || (v >= V_ACT - BPX);
    hs   = !((h >= H_ACT + H_FPW) && (h < H_ACT + H_FPW + H_SYW));
    vs   = !((v >= V_ACT + V_FPW) && (v < V_ACT + V_FPW + V_SYW));
    r3   = int'(c) / 32;
    g3   = (int'(c) / 4) % 8;
    b2   = int'(c) % 4;
    if (!vis) begin
      r = 8'd0; g = 8'd0; b = 8'd0;
    end else if (bord) begin
      r = 8'd255; g = 8'd255; b = 8'd255;
    end else begin
      r = 8'(r3 * 36 + r3 / 2);
      g = 8'(g3 * 36 + g3 / 2);
      b = 8'(b2 * 85);
    end
    return {hs, vs, vis, 1'(nn % 2), 1'b0, 1'b1, r, g, b};
  endfunction

  always @(negedge clk) begin
    logic [29:0] got;
    logic        txd_seen;
    if (mon_en) begin
      if (n == 0) begin
        m_colour  = 8'h00;
        m_pending = 8'h00;
      end
`ifdef UART_ECHO_EN
      txd_seen = (n == 0) ? txd : 1'b1;
`else
      txd_seen = txd;
`endif
      got = {vga_hs, vga_vs, vga_blank, vga_clk, vga_sync, txd_seen, vga_r, vga_g, vga_b};
      check_val("vga", {2'b0, got}, {2'b0, ref_vga(n, m_colour)});
      if (n >= 2 && (n - 2) % (2 * FR) == 0) begin
        m_colour = m_pending;
        -> fs_ev;
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic wait_fs();
    @(fs_ev);
    tick(1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    if (good_stop) begin
      rxd = 1'b1;
      tick(CPB);
      m_pending = b;
    end else begin
      rxd = 1'b0;
      tick(CPB * 3 / 4);
      rxd = 1'b1;
      tick(CPB);
    end
  endtask

`ifdef UART_ECHO_EN
  task automatic capture_echo(input logic [7:0] b);
    logic [9:0] exp_bits;
    int k;
    exp_bits = {1'b1, b, 1'b0};
    k = 0;
    while (txd !== 1'b0 && k < 20 * CPB) begin
      @(negedge clk);
      k++;
    end
    check_val("echo_start", 32'(k < 20 * CPB), 32'd1);
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check_val($sformatf("echo_bit%0d", i), {31'd0, txd}, {31'd0, exp_bits[i]});
      repeat (CPB) @(negedge clk);
    end
  endtask
`endif

  initial begin
    #4_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] c;
    rst = 1'b1;
    rxd = 1'b1;
    @(posedge clk);
    #2;
    mon_en = 1'b1;
    tick(3);
    rst = 1'b0;
    repeat (2) wait_fs();

    wait_fs();
    send_byte(8'hE0, 1'b1);

    for (int t = 0; t < 5; t++) begin
      c = 8'($urandom_range(0, 255));
      wait_fs();
      send_byte(c, 1'b1);
    end

    wait_fs();
    send_byte(8'h1C, 1'b1);
    send_byte(8'h03, 1'b1);
    repeat (2) wait_fs();

    send_byte(8'h55, 1'b0);
    wait_fs();
    rxd = 1'b0;
    tick(10);
    rxd = 1'b1;
    repeat (2) wait_fs();

`ifdef UART_ECHO_EN
    fork
      send_byte(8'h5A, 1'b1);
      capture_echo(8'h5A);
    join
    repeat (2) wait_fs();
`endif

    tick(300);
    rxd = 1'b0;
    tick(CPB);
    rxd = 1'b1;
    tick(CPB);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    rxd = 1'b1;
    repeat (2) wait_fs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
